// File: rtl/stdout_pkg.sv
// Shared definitions for the stdout UART transmitter: entry field layout,
// the fixed prefix bytes and the FSM state encoding.
package stdout_pkg;

   localparam int unsigned CHAR_LSB = 0;
   localparam int unsigned CHAR_W   = 8;
   localparam int unsigned CORE_LSB = 8;
   localparam int unsigned CL_LSB   = 12;
   localparam int unsigned IDX_W    = 4;

   localparam logic [7:0] NL_BYTE    = 8'h0A;
   localparam logic [7:0] LB_BYTE    = 8'h5B;
   localparam logic [7:0] COMMA_BYTE = 8'h2C;
   localparam logic [7:0] RB_BYTE    = 8'h5D;
   localparam logic [7:0] SP_BYTE    = 8'h20;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_NL,
      ST_LB,
      ST_CL,
      ST_COMMA,
      ST_CORE,
      ST_RB,
      ST_SP,
      ST_CHAR
   } state_e;

   // Lowercase ASCII hex digit for a 4-bit index.
   function automatic logic [7:0] hex_digit(input logic [3:0] v);
      if (v < 4'd10) return 8'h30 + {4'h0, v};
      else           return 8'h57 + {4'h0, v};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: baud down-counter plus 10-bit shifter, LSB first.
// done_o pulses during the last cycle of the stop bit so a new start can follow back-to-back.
module uart_tx_byte #(
   parameter int unsigned CLK_DIV = 868
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   output logic       tx_o,
   output logic       done_o
);

   localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

   logic [9:0]  shift_q;
   logic [15:0] baud_q;
   logic [3:0]  bit_q;
   logic        active_q;

   assign tx_o   = shift_q[0];
   assign done_o = active_q && (baud_q == 16'd0) && (bit_q == 4'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q  <= '1;
         baud_q   <= '0;
         bit_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         shift_q  <= {1'b1, byte_i, 1'b0};
         baud_q   <= BAUD_MAX;
         bit_q    <= 4'd9;
         active_q <= 1'b1;
      end else if (active_q) begin
         if (baud_q != 16'd0) begin
            baud_q <= baud_q - 16'd1;
         end else if (bit_q == 4'd0) begin
            // shifter already holds all ones here, so the line idles high
            active_q <= 1'b0;
         end else begin
            shift_q <= {1'b1, shift_q[9:1]};
            bit_q   <= bit_q - 4'd1;
            baud_q  <= BAUD_MAX;
         end
      end
   end

endmodule

// File: rtl/stdout_uart_tx.sv
// Drains core stdout entries onto a UART, prefixing each line with "[cluster,core] "
// and breaking the line when the source core changes mid-line.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_IDLE  | ready for an entry
// ST_NL    | sending 0x0A to close another source's line
// ST_LB    | sending '['
// ST_CL    | sending cluster hex digit
// ST_COMMA | sending ','
// ST_CORE  | sending core hex digit
// ST_RB    | sending ']'
// ST_SP    | sending ' '
// ST_CHAR  | sending the entry character
module stdout_uart_tx
   import stdout_pkg::*;
#(
   parameter int unsigned N_CLUSTERS = 4,
   parameter int unsigned N_CORES    = 8,
   parameter int unsigned CLK_DIV    = 868
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_data_i,
   output logic        tx_o,
   output logic        busy_o,
   output logic [15:0] drop_cnt_o
);

   state_e           state_q, state_d;
   logic             at_sol_q;
   logic [7:0]       last_src_q;
   logic [7:0]       char_q;
   logic [15:0]      drop_q;
   logic             ready_q;
   logic             busy_q;

   logic [IDX_W-1:0] in_cl, in_core;
   logic [7:0]       in_char, in_src;
   logic             accept, idx_ok;
   logic             tx_start, tx_done;
   logic [7:0]       tx_byte;
   logic             unused_hi;

   assign in_char   = in_data_i[CHAR_LSB +: CHAR_W];
   assign in_core   = in_data_i[CORE_LSB +: IDX_W];
   assign in_cl     = in_data_i[CL_LSB +: IDX_W];
   assign in_src    = {in_cl, in_core};
   assign unused_hi = ^in_data_i[31:16];

   assign accept = in_valid_i && (state_q == ST_IDLE);
   assign idx_ok = (32'(in_cl) < N_CLUSTERS) && (32'(in_core) < N_CORES);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && idx_ok) begin
               if (at_sol_q)                  state_d = ST_LB;
               else if (in_src != last_src_q) state_d = ST_NL;
               else                           state_d = ST_CHAR;
            end
         end
         ST_NL:    if (tx_done) state_d = ST_LB;
         ST_LB:    if (tx_done) state_d = ST_CL;
         ST_CL:    if (tx_done) state_d = ST_COMMA;
         ST_COMMA: if (tx_done) state_d = ST_CORE;
         ST_CORE:  if (tx_done) state_d = ST_RB;
         ST_RB:    if (tx_done) state_d = ST_SP;
         ST_SP:    if (tx_done) state_d = ST_CHAR;
         ST_CHAR:  if (tx_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Each byte is loaded on the edge that enters its state, which keeps frames back-to-back.
   always_comb begin
      tx_start = (state_d != state_q) && (state_d != ST_IDLE);
      tx_byte  = SP_BYTE;
      case (state_d)
         ST_NL:    tx_byte = NL_BYTE;
         ST_LB:    tx_byte = LB_BYTE;
         ST_CL:    tx_byte = hex_digit(last_src_q[7:4]);
         ST_COMMA: tx_byte = COMMA_BYTE;
         ST_CORE:  tx_byte = hex_digit(last_src_q[3:0]);
         ST_RB:    tx_byte = RB_BYTE;
         ST_SP:    tx_byte = SP_BYTE;
         ST_CHAR:  tx_byte = (state_q == ST_IDLE) ? in_char : char_q;
         default:  tx_byte = SP_BYTE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         at_sol_q   <= 1'b1;
         last_src_q <= '0;
         char_q     <= '0;
         drop_q     <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE);
         busy_q  <= (state_d != ST_IDLE);
         if (accept) begin
            if (idx_ok) begin
               last_src_q <= in_src;
               char_q     <= in_char;
            end else if (drop_q != 16'hFFFF) begin
               drop_q <= drop_q + 16'd1;
            end
         end
         if ((state_q == ST_CHAR) && tx_done) at_sol_q <= (char_q == NL_BYTE);
      end
   end

   uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (tx_start),
      .byte_i  (tx_byte),
      .tx_o    (tx_o),
      .done_o  (tx_done)
   );

   assign in_ready_o = ready_q;
   assign busy_o     = busy_q;
   assign drop_cnt_o = drop_q;

endmodule

// File: doc/stdout_uart_tx.md
STDOUT_UART_TX -- requirements
Module: stdout_uart_tx

Interface
REQ-001 SHALL have parameter N_CLUSTERS, default 4, number of clusters whose output is accepted.
REQ-002 SHALL have parameter N_CORES, default 8, number of cores per cluster whose output is accepted.
REQ-003 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit; legal range 2..65535.
REQ-004 clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 in_valid_i  input  1  stdout FIFO entry available.
REQ-007 in_ready_o  output  1  entry consumed in the cycle where in_valid_i && in_ready_o.
REQ-008 in_data_i  input  32  entry: [7:0] char, [11:8] core index, [15:12] cluster index, [31:16] ignored.
REQ-009 tx_o  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-010 busy_o  output  1  high whenever the state is not IDLE.
REQ-011 drop_cnt_o  output  16  count of entries discarded for out-of-range indices, saturating at 0xFFFF.

Function
REQ-012 FSM states: IDLE, NL, LB, CL, COMMA, CORE, RB, SP, CHAR; each non-IDLE state sends exactly one byte, then advances.
REQ-013 in_ready_o SHALL equal (state == IDLE); at most one entry is held at a time.
REQ-014 On accept, cluster >= N_CLUSTERS or core >= N_CORES: entry dropped, drop_cnt_o increments (saturating), state stays IDLE, no bytes sent.
REQ-015 On a valid accept, flag at_sol set: go to LB (prefix), latch source as last_src.
REQ-016 On a valid accept, at_sol clear and source != last_src: go to NL (send 0x0A), then LB; last_src updated.
REQ-017 On a valid accept, at_sol clear and same source: go directly to CHAR.
REQ-018 Prefix bytes in order: '[' (0x5B), cluster hex digit, ',' (0x2C), core hex digit, ']' (0x5D), ' ' (0x20), then CHAR.
REQ-019 Hex digit: value 0..9 -> 0x30+v, 10..15 -> 0x61+v-10 (lowercase).
REQ-020 CHAR sends the latched char unchanged; at_sol is set if char == 0x0A, cleared otherwise; then return to IDLE.
REQ-021 The prefix is sent before a 0x0A even if it is the only char on the line.
REQ-022 Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLK_DIV cycles; a frame is 10*CLK_DIV cycles.
REQ-023 The first start bit is driven in the cycle after the accept; consecutive bytes of one entry are back-to-back, with no idle bits between stop and the next start.
REQ-024 in_ready_o reasserts in the cycle after the final stop bit of CHAR completes.
REQ-025 in_valid_i is ignored while not IDLE; in_data_i is sampled only at accept.

Reset
REQ-026 Reset values: state IDLE, tx_o 1, in_ready_o 1, busy_o 0, drop_cnt_o 0, at_sol 1, last_src 0, baud and bit counters 0.
REQ-027 Reset asserted mid-frame SHALL force tx_o high immediately and abandon the current entry; no partial byte resumes after release.

Structure
REQ-028 Shared package stdout_pkg: entry field offsets and widths, prefix byte constants, FSM state enum.
REQ-029 A single sub-module, uart_tx_byte, SHALL hold the baud counter and 10-bit shifter: inputs start and byte, outputs tx and done (one-cycle pulse at the end of the stop bit).
REQ-030 The top level holds the FSM, index check, hex conversion, at_sol/last_src and drop counter.

Verification (CLK_DIV=4)
REQ-031 After reset, push 0x0000_1241 ('A', cl1, core2) -> bytes 5B 31 2C 32 5D 20 41, 280 cycles; in_ready_o low throughout, high at cycle 281.
REQ-032 Then push 0x0000_120A -> single byte 0A, with no prefix; next push 0x0000_1242 -> full prefix followed by 42.
REQ-033 Push 'x' from (0,0), then 'y' from (0,3) without a newline -> 0A, then prefix "[0,3] ", then 79.
REQ-034 N_CLUSTERS=4: push entry with cluster 5 -> no tx activity, drop_cnt_o=1, in_ready_o stays high; 0x10000 such drops -> drop_cnt_o=0xFFFF.
REQ-035 Assert rst_ni during the data bit 3 of '[' -> tx_o=1 the same cycle; after release, state IDLE and at_sol=1, and the next entry emits the full prefix.
REQ-036 Check every bit of every frame is high/low for exactly 4 cycles; cluster 10 core 15 (with N_CLUSTERS=N_CORES=16) -> digits 61 and 66.
